// File: rtl/mem_arbiter_if.sv
// Bundle of the request/ack ports for both cache refill paths and the main-memory port.
//   slave  : arbiter view. It receives the I/D requests and mem_rdata, and drives the acks,
//            the read data, the mem_* strobes, busy and grant_d.
//   master : environment view. Cache controllers plus the memory model; directions reversed.
interface mem_arbiter_if #(
  parameter int unsigned LINE_BITS = 128
) ();
  logic                 i_req;
  logic [31:0]          i_addr;
  logic                 i_ack;
  logic [LINE_BITS-1:0] i_rdata;

  logic                 d_req;
  logic                 d_we;
  logic [31:0]          d_addr;
  logic [LINE_BITS-1:0] d_wdata;
  logic                 d_ack;
  logic [LINE_BITS-1:0] d_rdata;

  logic                 mem_en;
  logic                 mem_we;
  logic [31:0]          mem_addr;
  logic [LINE_BITS-1:0] mem_wdata;
  logic [LINE_BITS-1:0] mem_rdata;

  logic                 busy;
  logic                 grant_d;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, grant_d
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, grant_d
  );
endinterface

// File: rtl/mem_arbiter.sv
// Main-memory arbiter shared by the I-side refill path and the D-side refill/writeback path.
// Each granted transfer holds mem_en for MEM_LATENCY cycles. The owner's ack then pulses for
// one cycle, together with the captured line on its *_rdata.
// Ports:
//   clock : system clock; all state updates on the rising edge.
//   reset : synchronous active-low reset.
//   bus   : mem_arbiter_if.slave. It carries the I/D request and ack channels, the memory
//           port, busy and grant_d.
module mem_arbiter #(
  parameter int unsigned LINE_BITS   = 128,
  parameter int unsigned MEM_LATENCY = 5
) (
  input  logic          clock,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned     CntW     = $clog2(MEM_LATENCY + 1);
  localparam logic [CntW-1:0] CntMax   = CntW'(MEM_LATENCY);
  // Clears the byte-offset bits within a line.
  localparam logic [31:0]     AddrMask = ~32'(LINE_BITS / 8 - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 owner_q, owner_d;
  logic                 last_grant_q, last_grant_d;
  logic                 mem_en_q, mem_en_d;
  logic                 mem_we_q, mem_we_d;
  logic [31:0]          mem_addr_q, mem_addr_d;
  logic [LINE_BITS-1:0] mem_wdata_q, mem_wdata_d;
  logic [LINE_BITS-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_BITS-1:0] d_rdata_q, d_rdata_d;
  logic                 pick_d;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    mem_en_d     = mem_en_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    pick_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.i_req || bus.d_req) begin
          // On a tie, the side that did not win last time gets the grant.
          pick_d       = bus.d_req && (!bus.i_req || !last_grant_q);
          owner_d      = pick_d;
          last_grant_d = pick_d;
          mem_addr_d   = (pick_d ? bus.d_addr : bus.i_addr) & AddrMask;
          mem_we_d     = pick_d && bus.d_we;
          mem_wdata_d  = pick_d ? bus.d_wdata : '0;
          mem_en_d     = 1'b1;
          cnt_d        = CntW'(1);
          state_d      = StAccess;
        end
      end
      StAccess: begin
        if (cnt_q == CntMax) begin
          // mem_rdata is valid in this last mem_en cycle; a write returns an all-zero line.
          if (owner_q) d_rdata_d = mem_we_q ? '0 : bus.mem_rdata;
          else         i_rdata_d = bus.mem_rdata;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          state_d  = StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.i_ack     = (state_q == StResp) && !owner_q;
  assign bus.d_ack     = (state_q == StResp) && owner_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.grant_d   = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int unsigned LB = 128;
  localparam logic [LB-1:0] RD_PAT  = 128'hDEAD0000_11112222_33334444_0000BEEF;
  localparam logic [LB-1:0] RD_PAT2 = 128'hCAFE0001_55556666_77778888_0000F00D;
  localparam logic [LB-1:0] WR_PAT  = 128'h11110000_AAAA5555_CCCC3333_00002222;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mem_arbiter_if #(.LINE_BITS(LB)) bus  ();
  mem_arbiter_if #(.LINE_BITS(LB)) bus1 ();
  mem_arbiter_if #(.LINE_BITS(LB)) bus8 ();

  mem_arbiter #(.LINE_BITS(LB), .MEM_LATENCY(5)) u_dut  (.clock(clock), .reset(reset), .bus(bus));
  mem_arbiter #(.LINE_BITS(LB), .MEM_LATENCY(1)) u_dut1 (.clock(clock), .reset(reset), .bus(bus1));
  mem_arbiter #(.LINE_BITS(LB), .MEM_LATENCY(8)) u_dut8 (.clock(clock), .reset(reset), .bus(bus8));

  int tests = 0;
  int fails = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_req  = 1'b0; bus.i_addr  = '0; bus.d_req  = 1'b0; bus.d_we  = 1'b0;
    bus.d_addr = '0;   bus.d_wdata = '0; bus.mem_rdata = '0;
    bus1.i_req  = 1'b0; bus1.i_addr  = '0; bus1.d_req  = 1'b0; bus1.d_we  = 1'b0;
    bus1.d_addr = '0;   bus1.d_wdata = '0; bus1.mem_rdata = '0;
    bus8.i_req  = 1'b0; bus8.i_addr  = '0; bus8.d_req  = 1'b0; bus8.d_we  = 1'b0;
    bus8.d_addr = '0;   bus8.d_wdata = '0; bus8.mem_rdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Observes the main DUT for ncyc cycles; requests drop in the cycle their ack is seen.
  task automatic watch(input int ncyc, output int en_cnt, output int we_cnt, output int ack_cyc,
                       output int last_en, output int i_acks, output int d_acks,
                       output logic [31:0] addr0, output logic [LB-1:0] wdata0, output bit stable);
    en_cnt = 0; we_cnt = 0; ack_cyc = -1; last_en = -1; i_acks = 0; d_acks = 0;
    addr0 = '0; wdata0 = '0; stable = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      tick();
      if (bus.mem_en === 1'b1) begin
        if (en_cnt == 0) begin
          addr0  = bus.mem_addr;
          wdata0 = bus.mem_wdata;
        end else if (bus.mem_addr !== addr0 || bus.mem_wdata !== wdata0) begin
          stable = 1'b0;
        end
        en_cnt++;
        last_en = k;
        if (bus.mem_we === 1'b1) we_cnt++;
      end
      if (bus.i_ack === 1'b1) begin
        i_acks++;
        if (ack_cyc < 0) ack_cyc = k;
        bus.i_req = 1'b0;
      end
      if (bus.d_ack === 1'b1) begin
        d_acks++;
        if (ack_cyc < 0) ack_cyc = k;
        bus.d_req = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    tick();
    tick();
    tests++;
    if ({bus.i_ack, bus.d_ack, bus.mem_en, bus.mem_we, bus.busy, bus.grant_d} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {bus.i_ack, bus.d_ack, bus.mem_en, bus.mem_we, bus.busy, bus.grant_d});
    end
    tests++;
    if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== '0) begin
      fails++;
      $display("FAIL reset_mem: got addr %h wdata %h want 0", bus.mem_addr, bus.mem_wdata);
    end
    tests++;
    if (bus.i_rdata !== '0 || bus.d_rdata !== '0) begin
      fails++;
      $display("FAIL reset_rdata: got %h / %h want 0", bus.i_rdata, bus.d_rdata);
    end
    reset = 1'b1;
    tick();
    tests++;
    if (bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: got busy %b want 0", bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    int en, we, ack, last, ia, da, dack_cnt;
    logic [31:0] a0;
    logic [LB-1:0] w0;
    bit st;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_0104; bus.mem_rdata = RD_PAT2;
    tick(); tick(); tick();
    tests++;
    if (bus.mem_en !== 1'b1) begin
      fails++;
      $display("FAIL mid_access3: got mem_en %b want 1", bus.mem_en);
    end
    reset = 1'b0;
    bus.d_req = 1'b0;
    tick();
    tests++;
    if (bus.mem_en !== 1'b0 || bus.busy !== 1'b0 || bus.d_ack !== 1'b0) begin
      fails++;
      $display("FAIL mid_abort: got en %b busy %b d_ack %b want 0 0 0",
               bus.mem_en, bus.busy, bus.d_ack);
    end
    reset = 1'b1;
    dack_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.d_ack !== 1'b0) dack_cnt++;
    end
    tests++;
    if (dack_cnt != 0) begin
      fails++;
      $display("FAIL mid_no_ack: got %0d d_ack cycles want 0", dack_cnt);
    end
    bus.d_req = 1'b1;
    watch(8, en, we, ack, last, ia, da, a0, w0, st);
    tests++;
    if (en != 5 || ack != 6 || da != 1 || ia != 0) begin
      fails++;
      $display("FAIL mid_reissue: got en %0d ack@%0d d %0d i %0d want 5 6 1 0", en, ack, da, ia);
    end
    tests++;
    if (a0 !== 32'h0000_0100 || bus.d_rdata !== RD_PAT2) begin
      fails++;
      $display("FAIL mid_reissue_data: got addr %h rdata %h want 00000100 %h",
               a0, bus.d_rdata, RD_PAT2);
    end
  endtask

  task automatic test_i_read();
    int en, we, ack, last, ia, da;
    logic [31:0] a0;
    logic [LB-1:0] w0;
    bit st;
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_0044; bus.mem_rdata = RD_PAT;
    watch(8, en, we, ack, last, ia, da, a0, w0, st);
    tests++;
    if (en != 5 || last != 5 || ack != 6) begin
      fails++;
      $display("FAIL i_read_timing: got en %0d last %0d ack@%0d want 5 5 6", en, last, ack);
    end
    tests++;
    if (ia != 1 || da != 0 || we != 0) begin
      fails++;
      $display("FAIL i_read_acks: got i %0d d %0d we %0d want 1 0 0", ia, da, we);
    end
    tests++;
    if (a0 !== 32'h0000_0040 || !st) begin
      fails++;
      $display("FAIL i_read_addr: got %h stable %0d want 00000040 1", a0, st);
    end
    tests++;
    if (bus.i_rdata !== RD_PAT || bus.d_rdata !== RD_PAT2) begin
      fails++;
      $display("FAIL i_read_rdata: got %h / %h want %h / %h",
               bus.i_rdata, bus.d_rdata, RD_PAT, RD_PAT2);
    end
  endtask

  task automatic test_d_write();
    int en, we, ack, last, ia, da;
    logic [31:0] a0;
    logic [LB-1:0] w0;
    bit st;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h0000_1238; bus.d_wdata = WR_PAT;
    watch(8, en, we, ack, last, ia, da, a0, w0, st);
    bus.d_we = 1'b0;
    tests++;
    if (en != 5 || we != 5 || ack != 6 || da != 1 || ia != 0) begin
      fails++;
      $display("FAIL d_write_timing: got en %0d we %0d ack@%0d d %0d i %0d want 5 5 6 1 0",
               en, we, ack, da, ia);
    end
    tests++;
    if (a0 !== 32'h0000_1230 || w0 !== WR_PAT || !st) begin
      fails++;
      $display("FAIL d_write_bus: got addr %h wdata %h stable %0d want 00001230 %h 1",
               a0, w0, st, WR_PAT);
    end
    tests++;
    if (bus.d_rdata !== '0 || bus.i_rdata !== RD_PAT) begin
      fails++;
      $display("FAIL d_write_rdata: got %h / %h want 0 / %h", bus.d_rdata, bus.i_rdata, RD_PAT);
    end
  endtask

  task automatic test_tie();
    int n, both, at_c[4];
    bit who[4];
    logic busy7, g1, g8;
    do_reset();
    n = 0; both = 0; busy7 = 1'bx; g1 = 1'bx; g8 = 1'bx;
    for (int i = 0; i < 4; i++) begin at_c[i] = -1; who[i] = 1'b0; end
    bus.i_addr = 32'h0000_0200; bus.d_addr = 32'h0000_0300; bus.mem_rdata = RD_PAT;
    bus.i_req = 1'b1; bus.d_req = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (k == 1) g1 = bus.grant_d;
      if (k == 7) busy7 = bus.busy;
      if (k == 8) g8 = bus.grant_d;
      if (bus.i_ack === 1'b1 && bus.d_ack === 1'b1) both++;
      if ((bus.i_ack === 1'b1 || bus.d_ack === 1'b1) && n < 4) begin
        who[n]  = bus.d_ack;
        at_c[n] = k;
        n++;
        if (n == 4) begin bus.i_req = 1'b0; bus.d_req = 1'b0; end
      end
    end
    tests++;
    if (n != 4 || both != 0) begin
      fails++;
      $display("FAIL tie_count: got %0d acks %0d overlaps want 4 0", n, both);
    end
    tests++;
    if ({who[0], who[1], who[2], who[3]} !== 4'b1010) begin
      fails++;
      $display("FAIL tie_order: got %b want 1010 (1=D)", {who[0], who[1], who[2], who[3]});
    end
    tests++;
    if (at_c[0] != 6 || at_c[1] != 13 || at_c[2] != 20 || at_c[3] != 27) begin
      fails++;
      $display("FAIL tie_spacing: got %0d %0d %0d %0d want 6 13 20 27",
               at_c[0], at_c[1], at_c[2], at_c[3]);
    end
    tests++;
    if (busy7 !== 1'b0 || g1 !== 1'b1 || g8 !== 1'b0) begin
      fails++;
      $display("FAIL tie_grant: got busy7 %b grant_d@1 %b @8 %b want 0 1 0", busy7, g1, g8);
    end
  endtask

  task automatic test_late_arrival();
    int d_at, i_at;
    bit addr_bad;
    logic [31:0] addr8;
    logic en8;
    d_at = -1; i_at = -1; addr_bad = 1'b0; addr8 = '0; en8 = 1'b0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_0500; bus.i_addr = 32'h0000_0600;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k <= 5 && (bus.mem_en !== 1'b1 || bus.mem_addr !== 32'h0000_0500)) addr_bad = 1'b1;
      if (k == 8) begin addr8 = bus.mem_addr; en8 = bus.mem_en; end
      if (bus.d_ack === 1'b1) begin if (d_at < 0) d_at = k; bus.d_req = 1'b0; end
      if (bus.i_ack === 1'b1) begin if (i_at < 0) i_at = k; bus.i_req = 1'b0; end
      if (k == 2) bus.i_req = 1'b1;
    end
    tests++;
    if (d_at != 6 || i_at != 13) begin
      fails++;
      $display("FAIL late_acks: got d_ack@%0d i_ack@%0d want 6 13", d_at, i_at);
    end
    tests++;
    if (addr_bad || addr8 !== 32'h0000_0600 || en8 !== 1'b1) begin
      fails++;
      $display("FAIL late_addr: got d_bad %0d addr@8 %h en@8 %b want 0 00000600 1",
               addr_bad, addr8, en8);
    end
  endtask

  task automatic test_sweep();
    int en, last, ack, acks, we;
    en = 0; last = -1; ack = -1; acks = 0;
    bus1.i_req = 1'b1; bus1.i_addr = 32'h0000_0080; bus1.mem_rdata = RD_PAT;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (bus1.mem_en === 1'b1) begin en++; last = k; end
      if (bus1.i_ack === 1'b1) begin acks++; if (ack < 0) ack = k; bus1.i_req = 1'b0; end
    end
    tests++;
    if (en != 1 || last != 1 || ack != 2 || acks != 1 || bus1.i_rdata !== RD_PAT) begin
      fails++;
      $display("FAIL sweep_lat1: got en %0d last %0d ack@%0d acks %0d rdata %h want 1 1 2 1 %h",
               en, last, ack, acks, bus1.i_rdata, RD_PAT);
    end
    en = 0; last = -1; ack = -1; acks = 0; we = 0;
    bus8.d_req = 1'b1; bus8.d_we = 1'b1; bus8.d_addr = 32'h0000_0084; bus8.d_wdata = WR_PAT;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (bus8.mem_en === 1'b1) begin en++; last = k; if (bus8.mem_we === 1'b1) we++; end
      if (bus8.d_ack === 1'b1) begin acks++; if (ack < 0) ack = k; bus8.d_req = 1'b0; end
    end
    tests++;
    if (en != 8 || last != 8 || ack != 9 || acks != 1 || we != 8) begin
      fails++;
      $display("FAIL sweep_lat8: got en %0d last %0d ack@%0d acks %0d we %0d want 8 8 9 1 8",
               en, last, ack, acks, we);
    end
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    test_reset();
    test_reset_mid();
    test_i_read();
    test_d_write();
    test_tie();
    test_late_arrival();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single main-memory port between the instruction-fetch refill path (I side) and the data-access refill/writeback path (D side). It sequences each transfer over a fixed MEM_LATENCY-cycle memory access and returns line data through a one-cycle ack. Requesters stall while their request is waiting or in flight. It sits between the fetch/memory-stage cache controllers and the main-memory array model.

Parameters:
LINE_BITS, 128, width of one memory line or transfer in bits; must be a power of two and at least 32.
MEM_LATENCY, 5, number of cycles mem_en is held per transfer; must be at least 1.

Ports:
clock  in  1  system clock; all state updates on the rising edge.
reset  in  1  synchronous, active-low reset; sampled on the rising edge of clock.
i_req  in  1  I-side request; held high until i_ack.
i_addr  in  32  I-side byte address.
i_ack  out  1  one-cycle pulse; I transfer complete, i_rdata valid this cycle.
i_rdata  out  LINE_BITS  I-side read line.
d_req  in  1  D-side request; held high until d_ack.
d_we  in  1  D-side write (1) or read (0).
d_addr  in  32  D-side byte address.
d_wdata  in  LINE_BITS  D-side write line.
d_ack  out  1  one-cycle pulse; D transfer complete.
d_rdata  out  LINE_BITS  D-side read line.
mem_en  out  1  memory access active.
mem_we  out  1  memory write strobe, qualified by mem_en.
mem_addr  out  32  line-aligned memory address.
mem_wdata  out  LINE_BITS  memory write data.
mem_rdata  in  LINE_BITS  memory read data; valid in the last mem_en cycle.
busy  out  1  a transfer is granted or being acknowledged, i.e. state is not IDLE.
grant_d  out  1  current or last owner: 1 means D, 0 means I.

Behaviour:
- States: IDLE, ACCESS, RESP. Registers: state, cnt (clog2(MEM_LATENCY+1) bits), owner, last_grant, mem_* and rdata.
- Reset (reset==0 at an edge): state=IDLE, cnt=0, owner=0, last_grant=0, and all outputs 0. This includes i_ack, d_ack, mem_en, mem_we, mem_addr, mem_wdata, i_rdata, d_rdata, busy and grant_d. An in-flight transfer is abandoned and no ack is issued for it.
- IDLE: if neither request is high, stay in IDLE.
  - Only one request high: grant it.
  - Both requests high: round-robin. Grant the side not equal to last_grant. After reset, last_grant=I, so D wins the first tie.
  - On a grant: latch owner and last_grant. Set mem_addr = requester addr with bits [log2(LINE_BITS/8)-1:0] zeroed. Set mem_we = d_we for D, 0 for I. Set mem_wdata = d_wdata for D, 0 for I. Set mem_en=1, cnt=1, go to ACCESS.
- ACCESS: mem_en=1 and mem_addr/mem_we/mem_wdata are held stable for exactly MEM_LATENCY consecutive cycles.
  - When cnt==MEM_LATENCY: capture mem_rdata into rdata (writes capture 0), drop mem_en and mem_we, go to RESP.
  - Otherwise cnt increments.
- RESP: for one cycle, assert the owner's ack (i_ack or d_ack) and drive rdata on the owner's *_rdata. Then go to IDLE.
- Latency: a request sampled high in IDLE at edge t gives mem_en high for cycles t+1 … t+MEM_LATENCY and ack high in cycle t+MEM_LATENCY+1. The total is MEM_LATENCY+1 cycles from grant to ack.
- Requester rule: req must be low in the cycle after its ack. The arbiter re-samples only in IDLE, so the earliest next grant is at the edge ending the first IDLE cycle.
- Idle gap: there is at least one IDLE cycle between consecutive transfers.
- The non-granted request waits with no ack. The arbiter does not latch it; it is sampled only in IDLE.
- Request inputs changing during ACCESS or RESP are ignored, because mem_* outputs are registered at grant.
- *_rdata holds its last value between acks. Only the owner's rdata output updates in RESP.
- i_ack and d_ack are never high in the same cycle. At most one ack is issued per grant.
- busy = (state != IDLE). grant_d = owner.

Test Plan:
- Reset mid-transfer: d_req=1, d_we=0, d_addr=0x0000_0104. Drive reset=0 in the 3rd ACCESS cycle → next cycle mem_en=0, busy=0, and d_ack never pulses. Reissue the request → full 5-cycle access, then ack.
- Single I read: i_req=1, i_addr=0x0000_0044, mem_rdata=0xDEAD…BEEF → mem_addr=0x0000_0040 and mem_en=1 for exactly 5 cycles, i_ack in cycle 6 after grant with i_rdata=0xDEAD…BEEF, d_ack=0 throughout.
- D write: d_req=1, d_we=1, d_addr=0x0000_1238, d_wdata=0x1111…2222 → mem_addr=0x0000_1230, mem_we=1 for 5 cycles, mem_wdata=0x1111…2222, single d_ack pulse.
- Simultaneous requests from reset: i_req=d_req=1 held → grant order D, I, D, I, observed via grant_d and ack order. Each ack is separated by 6 cycles plus one IDLE cycle.
- Late arrival: i_req raised during a D ACCESS → no i_ack until the D transfer acks. I is granted on the following IDLE cycle; mem_addr stays at the D address until the D access completes.
- Parameter sweep: MEM_LATENCY=1 and MEM_LATENCY=8 → mem_en width equals MEM_LATENCY, and ack follows exactly one cycle after the last mem_en cycle.
